mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 output mux between four requesters. It grants ownership of the mux to one requester at a time, drives the 2-bit select, and presents the selected input with a valid flag. Downstream logic sees one arbitrated channel; upstream agents only assert and hold a request line.

## Interface
- `WIDTH`, 1: data width of each input and of `out`.
- `MAX_HOLD`, 8: maximum consecutive grant cycles under contention; used only when `MUX_ARB_TIMEOUT_EN` is defined; legal range 2..255.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  4  request per requester; `req[i]` is held high until the requester is done.
- `in0`..`in3`  input  WIDTH each  requester data.
- `gnt`  output  4  one-hot registered grant; never more than one bit high.
- `sel`  output  2  registered mux select, equal to the index of the granted requester.
- `valid`  output  1  equals `|gnt`.
- `out`  output  WIDTH  `in[sel]` when `valid`, else 0; combinational from `sel`/`valid` and the inputs.

## Operation
- Two states: IDLE (no grant) and GRANT (one owner).
- Round-robin pointer `last` (2 bits) holds the most recently granted index. Search order is `last+1`, `last+2`, `last+3`, `last`, modulo 4. The first requester in this order with `req` high wins.
- IDLE: if `req != 0`, grant the winner, load `sel`, set `last` to the winner, and move to GRANT. Otherwise stay.
- GRANT with `req[owner]` high and no timeout: hold `gnt`, `sel`, and the owner.
- GRANT with `req[owner]` low (release): re-arbitrate over `req` with the owner's bit masked.
  - If another requester is pending, hand off on the same edge: GRANT→GRANT with the new owner and no idle cycle.
  - Otherwise clear `gnt` and go to IDLE.
- `sel` keeps its last value while IDLE. `out` is forced to 0 by `valid` = 0.
- Requests that drop before they are granted are ignored; there is no request memory.

## Timing
- Reset values: `gnt`=0000, `sel`=00, `valid`=0, `out`=0, `last`=3 (requester 0 has first priority), state IDLE, hold counter 0.
- Reset is asynchronous: asserting `rst` mid-grant clears `gnt`/`valid` immediately, without waiting for a clock edge. The first edge after deassertion arbitrates from `last`=3.
- Grant latency: `req[i]` high at edge k while IDLE → `gnt[i]` and `sel` update at edge k; visible during cycle k+1.
- Release latency: `req[owner]` low at edge k → the grant moves or clears at edge k.
- Simultaneous requests at the same edge are resolved purely by the pointer order.
- Pointer wrap: 3+1 wraps to 0.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on every new grant and increments each cycle in GRANT.
  - When the counter reaches `MAX_HOLD-1` and another requester is pending, the grant is forced to the next winner at that edge, even though `req[owner]` is high.
  - If no other requester is pending, the owner keeps the grant and the counter saturates at `MAX_HOLD-1`.
- Not defined: no counter. The owner holds the grant until it releases.

## Test plan
- Reset: `rst`=1 with `req`=1111 → `gnt`=0000, `sel`=00, `valid`=0, `out`=0. Assert `rst` mid-grant → `gnt` is 0 before the next edge.
- Single request: `req`=0100, `in2`=1 → after 1 edge, `gnt`=0100, `sel`=10, `valid`=1, `out`=1. Drop `req[2]` → next edge `gnt`=0000, `out`=0.
- Rotation: `req`=1111, each owner drops its request for one cycle after 2 granted cycles → grant order 0,1,2,3,0 with `sel`=00,01,10,11,00.
- Handoff: owner 0 holding, `req[3]` pending, drop `req[0]` → at the same edge `gnt`=1000, `sel`=11, with no cycle of `valid`=0.
- Timeout (`MUX_ARB_TIMEOUT_EN`, `MAX_HOLD`=4): `req`=0011 held → `gnt`=0001 for 4 cycles, then 0010 for 4, alternating. With the macro undefined → `gnt` stays 0001 indefinitely.
- Timeout with no contention (`MUX_ARB_TIMEOUT_EN`): `req`=0001 held for 20 cycles → `gnt`=0001 throughout.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter that owns a shared 4:1 mux. One requester at a time is
// granted the mux. The grant and select are registered, and the selected input
// is presented downstream with a valid flag.
//
// Optional feature macro: MUX_ARB_TIMEOUT_EN
//   When defined, an owner that has held the grant for MAX_HOLD cycles is
//   forced to hand over when another requester is pending. When undefined,
//   the owner keeps the grant until it drops its request.
//
// Parameters:
//   WIDTH     data width of in0..in3 and out
//   MAX_HOLD  maximum consecutive grant cycles under contention (2..255).
//             Only used with MUX_ARB_TIMEOUT_EN.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req[3:0]   request per requester, held high while it wants the mux
//   in0..in3   requester data
//   gnt[3:0]   one-hot registered grant
//   sel[1:0]   registered mux select (index of the granted requester)
//   valid      |gnt
//   out        in[sel] while valid, otherwise 0 (combinational)
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] out
);

  // Reject an illegal hold limit at elaboration time.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_check
    $error("mux_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic [1:0] last_q;

  // In GRANT, sel_q is always the owner's index.
  logic [3:0] owner_mask;
  logic       owner_req;
  logic [3:0] cand;

  assign owner_mask = 4'b0001 << sel_q;
  assign owner_req  = |(req & owner_mask);
  // While someone owns the mux, the owner never competes against itself.
  // This lets a release or a timeout hand the grant straight to somebody else.
  assign cand       = (state_q == GRANT) ? (req & ~owner_mask) : req;

  // Rotate the candidates so that bit 0 is the index after last_q. A plain
  // lowest-bit-first priority encode then gives the round-robin order.
  logic [3:0] rot;
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    logic [1:0] idx;
    assign idx     = last_q + 2'(gi + 1);
    assign rot[gi] = cand[idx];
  end

  logic       win_found;
  logic [1:0] win_off;
  logic [1:0] win_idx;

  always_comb begin
    win_found = |rot;
    win_off   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) win_off = 2'(k);
    end
  end

  assign win_idx = last_q + win_off + 2'd1;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q;
  logic       hold_expired;
  assign hold_expired = (hold_q == HOLD_LAST);
`else
  logic       hold_expired;
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;  // requester 0 searched first after reset
`ifdef MUX_ARB_TIMEOUT_EN
      hold_q  <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= GRANT;
            gnt_q   <= 4'b0001 << win_idx;
            sel_q   <= win_idx;
            last_q  <= win_idx;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q  <= 8'd0;
`endif
          end
        end
        GRANT: begin
          // The owner keeps the mux unless it releases. It also gives it up if
          // the hold limit is hit while someone else is waiting.
          if (owner_req && !(hold_expired && win_found)) begin
`ifdef MUX_ARB_TIMEOUT_EN
            if (!hold_expired) hold_q <= hold_q + 8'd1;
`endif
          end else if (win_found) begin
            gnt_q   <= 4'b0001 << win_idx;
            sel_q   <= win_idx;
            last_q  <= win_idx;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q  <= 8'd0;
`endif
          end else begin
            // sel_q deliberately keeps its value while idle.
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = |gnt_q;

  always_comb begin
    out = '0;
    if (valid) begin
      case (sel_q)
        2'd0:    out = in0;
        2'd1:    out = in1;
        2'd2:    out = in2;
        default: out = in3;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mux_rr_arbiter. A behavioural reference model predicts the
// grant, select, valid and output values for every clock step. Each prediction
// goes into a queue and is compared after the edge. The scenario tasks also
// check the fixed grant patterns the arbiter must produce.
// Expectations follow MUX_ARB_TIMEOUT_EN when the bench is built with it.
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int W  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] in_v [4];
  logic [W-1:0] in0, in1, in2, in3;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         valid;
  logic [W-1:0] out;

  assign in0 = in_v[0];
  assign in1 = in_v[1];
  assign in2 = in_v[2];
  assign in3 = in_v[3];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .out   (out)
  );

  typedef struct packed {
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         valid;
    logic [W-1:0] out;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_steps = 0;

  // Reference model state
  logic [3:0] m_gnt;
  logic [1:0] m_sel;
  logic [1:0] m_last;
  int         m_hold;
  bit         m_busy;

  task automatic model_reset();
    m_gnt  = 4'b0000;
    m_sel  = 2'd0;
    m_last = 2'd3;
    m_hold = 0;
    m_busy = 0;
    sb.delete();
  endtask

  // One clock edge of the arbiter for request vector r.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] cand;
    int         win;
    bit         keep;
    cand = r;
    keep = 0;
    if (m_busy) begin
      cand[m_sel] = 1'b0;
      keep = r[m_sel];
`ifdef MUX_ARB_TIMEOUT_EN
      if (keep && m_hold == MH - 1 && cand != 4'b0000) keep = 0;
`endif
    end
    if (keep) begin
      if (m_hold < MH - 1) m_hold++;
      return;
    end
    win = -1;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(m_last) + k) % 4;
      if (win < 0 && cand[idx]) win = idx;
    end
    if (win >= 0) begin
      m_busy = 1;
      m_sel  = win[1:0];
      m_last = win[1:0];
      m_gnt  = 4'b0001 << win;
      m_hold = 0;
    end else begin
      m_busy = 0;
      m_gnt  = 4'b0000;
    end
  endtask

  // Called at a negedge: drives r, predicts, clocks, checks #1 after the edge,
  // then returns at the next negedge.
  task automatic step(input logic [3:0] r, output logic [3:0] o_gnt, output logic [1:0] o_sel);
    exp_t e;
    exp_t got;
    req = r;
    model_step(r);
    e.gnt   = m_gnt;
    e.sel   = m_sel;
    e.valid = m_busy;
    e.out   = m_busy ? in_v[m_sel] : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_steps++;
    got = {gnt, sel, valid, out};
    e = sb.pop_front();
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL step%0d req=%b: got gnt=%b sel=%0d valid=%b out=%h, want gnt=%b sel=%0d valid=%b out=%h",
               n_steps, r, gnt, sel, valid, out, e.gnt, e.sel, e.valid, e.out);
    end else begin
      $display("[TB] step %0d req=%b gnt=%b sel=%0d valid=%b out=%h", n_steps, r, gnt, sel, valid, out);
    end
    o_gnt = gnt;
    o_sel = sel;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [3:0] g;
    logic [1:0] s;
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) in_v[i] = '1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({gnt, sel, valid, out} !== {4'b0000, 2'd0, 1'b0, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_values: got gnt=%b sel=%0d valid=%b out=%h, want 0000/0/0/0", gnt, sel, valid, out);
    end
    rst = 1'b0;
    model_reset();
    step(4'b0010, g, s);
    // Assert reset between edges; the grant has to vanish at once.
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (gnt !== 4'b0000 || valid !== 1'b0 || out !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got gnt=%b valid=%b out=%h, want 0000/0/0", gnt, valid, out);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b1111, g, s);
    n_tests++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_reset_priority: got gnt=%b, want 0001", g);
    end
  endtask

  task automatic test_single_request();
    logic [3:0] g;
    logic [1:0] s;
    do_reset();
    in_v[0] = '0; in_v[1] = '0; in_v[2] = 4'd1; in_v[3] = '0;
    step(4'b0100, g, s);
    n_tests++;
    if (g !== 4'b0100 || s !== 2'd2 || valid !== 1'b1 || out !== 4'd1) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%b sel=%0d valid=%b out=%h, want 0100/2/1/1", g, s, valid, out);
    end
    step(4'b0000, g, s);
    n_tests++;
    if (g !== 4'b0000 || valid !== 1'b0 || out !== '0 || s !== 2'd2) begin
      n_fail++;
      $display("FAIL single_release: got gnt=%b sel=%0d valid=%b out=%h, want 0000/2/0/0", g, s, valid, out);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] g;
    logic [1:0] s;
    logic [1:0] order [5];
    do_reset();
    for (int i = 0; i < 4; i++) in_v[i] = 4'(i + 5);
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    step(4'b1111, g, s);
    for (int n = 0; n < 5; n++) begin
      n_tests++;
      if (s !== order[n] || g !== (4'b0001 << order[n])) begin
        n_fail++;
        $display("FAIL rotation_%0d: got gnt=%b sel=%0d, want sel=%0d", n, g, s, order[n]);
      end
      if (n < 4) begin
        step(4'b1111, g, s);
        step(4'b1111 & ~(4'b0001 << order[n]), g, s);
      end
    end
  endtask

  task automatic test_handoff();
    logic [3:0] g;
    logic [1:0] s;
    do_reset();
    step(4'b0001, g, s);
    step(4'b1001, g, s);
    step(4'b1000, g, s);
    n_tests++;
    if (g !== 4'b1000 || s !== 2'd3 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL handoff: got gnt=%b sel=%0d valid=%b, want 1000/3/1", g, s, valid);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] g;
    logic [1:0] s;
    logic [3:0] want;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      step(4'b0011, g, s);
`ifdef MUX_ARB_TIMEOUT_EN
      want = ((n / MH) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      want = 4'b0001;
`endif
      n_tests++;
      if (g !== want) begin
        n_fail++;
        $display("FAIL timeout_cycle%0d: got gnt=%b, want %b", n, g, want);
      end
    end
  endtask

  task automatic test_no_contention();
    logic [3:0] g;
    logic [1:0] s;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      step(4'b0001, g, s);
      n_tests++;
      if (g !== 4'b0001) begin
        n_fail++;
        $display("FAIL hold_alone_cycle%0d: got gnt=%b, want 0001", n, g);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] g;
    logic [1:0] s;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < 4; i++) in_v[i] = W'($urandom);
      step(4'($urandom_range(0, 15)), g, s);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) in_v[i] = '0;
    model_reset();
    test_reset();
    test_single_request();
    test_rotation();
    test_handoff();
    test_timeout();
    test_no_contention();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, steps=%0d", n_steps);
    $fatal(1, "watchdog expired");
  end

endmodule
